// File: rtl/fb_pixel_writer_pkg.sv
// Shared constants, entry layout and state encoding for the framebuffer pixel writer.
// Pixel coordinates are converted to linear addresses here without a multiplier.
package fb_pixel_writer_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_SIZE  = FB_W * FB_H;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_CLEAR = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } fb_entry_t;

    localparam int ENTRY_W = $bits(fb_entry_t);

    // y*160 + x as (y<<7) + (y<<5) + x; only called with in-range coordinates.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [COORD_W-1:0] px,
                                                     input logic [COORD_W-1:0] py);
        logic [ADDR_W-1:0] xx;
        logic [ADDR_W-1:0] yy;
        xx = ADDR_W'(px);
        yy = ADDR_W'(py);
        return (yy << 7) + (yy << 5) + xx;
    endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// Small synchronous FIFO buffering {address, colour} entries ahead of the framebuffer port.
// Push is ignored when full and pop is ignored when empty; both may occur on the same edge.
module fb_pixel_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define validity,
    // and leaving the array unreset lets it map onto plain RAM/register cells.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel-stream sink: bounds-checks and buffers draw requests, converts them to linear
// framebuffer addresses, issues one RAM write per cycle and runs full-screen clears.
module fb_pixel_writer #(
    parameter int FB_W       = fb_pixel_writer_pkg::FB_W,
    parameter int FB_H       = fb_pixel_writer_pkg::FB_H,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        plot,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [2:0]  colour,
    output logic        ready,
    input  logic        clear_go,
    input  logic [2:0]  clear_colour,
    output logic        busy,
    output logic        clear_done,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [2:0]  wr_data,
    output logic [7:0]  drop_count
);

    import fb_pixel_writer_pkg::*;

    localparam int PIXELS = FB_W * FB_H;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    wr_state_t           state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [COLOUR_W-1:0] clr_colour;

    fb_entry_t           push_entry;
    fb_entry_t           head;
    logic [ENTRY_W-1:0]  head_raw;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    logic                in_range;
    logic                push;
    logic                pop;
    logic                drop;

    assign in_range = (x < COORD_W'(FB_W)) && (y < COORD_W'(FB_H));

    // NOTE: ready is gated with resetn directly so it falls the instant reset is
    // asserted, without waiting for any register to be cleared.
    assign ready = resetn && (state == ST_IDLE) && !fifo_full;
    assign push  = plot && ready && in_range;
    assign drop  = plot && !(ready && in_range);
    assign pop   = (state != ST_CLEAR) && !fifo_empty;
    assign busy  = (state != ST_IDLE);

    assign push_entry = '{addr: pixel_addr(x, y), colour: colour};
    assign head       = fb_entry_t'(head_raw);

    fb_pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            clr_cnt    <= '0;
            clr_colour <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            clear_done <= 1'b0;
            drop_count <= '0;
        end else begin
            // NOTE: strobes default low every cycle; the branches below raise them
            // only on the cycles they apply, while wr_addr/wr_data keep their value.
            wr_en      <= 1'b0;
            clear_done <= 1'b0;

            if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        wr_en   <= 1'b1;
                        wr_addr <= head.addr;
                        wr_data <= head.colour;
                    end
                    if (clear_go) begin
                        clr_colour <= clear_colour;
                        clr_cnt    <= '0;
                        state      <= ST_FLUSH;
                    end
                end

                ST_FLUSH: begin
                    if (fifo_count != '0) begin
                        wr_en   <= 1'b1;
                        wr_addr <= head.addr;
                        wr_data <= head.colour;
                    end else begin
                        // The cycle that finds the buffer empty already writes clear
                        // address 0, so a clear costs exactly occupancy + PIXELS cycles.
                        wr_en   <= 1'b1;
                        wr_addr <= clr_cnt;
                        wr_data <= clr_colour;
                        clr_cnt <= clr_cnt + 1'b1;
                        state   <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= clr_cnt;
                    wr_data <= clr_colour;
                    if (clr_cnt == ADDR_W'(PIXELS - 1)) begin
                        clr_cnt    <= '0;
                        clear_done <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
